// File: rtl/altusoc_gpio_pkg.sv
// Shared register map and address helpers for the AltuSOC GPIO input block.
package altusoc_gpio_pkg;

    typedef logic [4:0] gpio_addr_t;

    // Byte offsets of the software-visible registers.
    localparam gpio_addr_t ADDR_DATA      = 5'h00;
    localparam gpio_addr_t ADDR_RISE_EN   = 5'h04;
    localparam gpio_addr_t ADDR_FALL_EN   = 5'h08;
    localparam gpio_addr_t ADDR_STATUS    = 5'h0C;
    localparam gpio_addr_t ADDR_IRQ_EN    = 5'h10;
    localparam gpio_addr_t ADDR_DB_CYCLES = 5'h14;

    localparam int unsigned REG_WIDTH = 32;

    // Registers are word aligned; the byte-lane bits never select anything.
    function automatic gpio_addr_t word_addr(input gpio_addr_t addr);
        return {addr[4:2], 2'b00};
    endfunction

endpackage

// File: rtl/altusoc_gpio_in_filter.sv
// Per-pin synchroniser and debounce filter with edge pulses.
module altusoc_gpio_in_filter
    import altusoc_gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                gpio_i,
    input  logic [DB_WIDTH-1:0] db_cycles_i,
    input  logic                prime_i,
    output logic                filt_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt_q, filt_d;
    logic [DB_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   update;

    assign sync = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
        end
    end

    // Debounce decision; rise/fall flag the edge on which filt will change.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        update = 1'b0;
        if (prime_i) begin
            // Right after reset the filter just tracks the pin, so no edge is reported.
            filt_d = sync;
            cnt_d  = '0;
        end else if (sync == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= db_cycles_i) begin
            // >= lets a lowered threshold act at once and keeps cnt from wrapping.
            filt_d = sync;
            cnt_d  = '0;
            update = 1'b1;
        end else begin
            cnt_d = cnt_q + DB_WIDTH'(1);
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = update & sync;
    assign fall_o = update & ~sync;

endmodule

// File: rtl/altusoc_gpio_in.sv
// GPIO input capture: per-pin filters, edge status, interrupt and register port.
module altusoc_gpio_in
    import altusoc_gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_WIDTH    = 8,
    parameter int unsigned DB_RESET    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_GPIO-1:0] i_gpio,
    input  logic                cfg_wr,
    input  logic                cfg_rd,
    input  logic [4:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    output logic [NUM_GPIO-1:0] o_gpio_filt,
    output logic                o_irq
);

    localparam int unsigned PRIME_LEN = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_LEN + 1);

    gpio_addr_t                addr_word;
    logic [NUM_GPIO-1:0]       filt, rise, fall;
    logic [NUM_GPIO-1:0]       rise_en_q, fall_en_q, irq_en_q;
    logic [NUM_GPIO-1:0]       status_q, status_d, status_clr;
    logic [DB_WIDTH-1:0]       db_cycles_q;
    logic [REG_WIDTH-1:0]      rdata_q, rdata_d;
    logic [PRIME_W-1:0]        prime_cnt_q;
    logic                      prime;
    logic                      unused_bits;

    assign addr_word   = word_addr(cfg_addr);
    assign prime       = (prime_cnt_q != PRIME_W'(PRIME_LEN));
    assign unused_bits = ^{cfg_addr[1:0], cfg_wdata};

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        altusoc_gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_WIDTH    (DB_WIDTH)
        ) u_filter (
            .clk         (clk),
            .rst_n       (rst_n),
            .gpio_i      (i_gpio[i]),
            .db_cycles_i (db_cycles_q),
            .prime_i     (prime),
            .filt_o      (filt[i]),
            .rise_o      (rise[i]),
            .fall_o      (fall[i])
        );
    end

    // Count the post-reset priming window, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
        end else if (prime) begin
            prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            irq_en_q    <= '0;
            db_cycles_q <= DB_WIDTH'(DB_RESET);
        end else if (cfg_wr) begin
            case (addr_word)
                ADDR_RISE_EN:   rise_en_q   <= cfg_wdata[NUM_GPIO-1:0];
                ADDR_FALL_EN:   fall_en_q   <= cfg_wdata[NUM_GPIO-1:0];
                ADDR_IRQ_EN:    irq_en_q    <= cfg_wdata[NUM_GPIO-1:0];
                ADDR_DB_CYCLES: db_cycles_q <= cfg_wdata[DB_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Sticky status: W1C first, then new edges, so a same-cycle set wins.
    always_comb begin
        status_clr = '0;
        if (cfg_wr && (addr_word == ADDR_STATUS)) begin
            status_clr = cfg_wdata[NUM_GPIO-1:0];
        end
        status_d = (status_q & ~status_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // Read mux over the current register values (pre-write on a same-cycle write).
    always_comb begin
        rdata_d = '0;
        case (addr_word)
            ADDR_DATA:      rdata_d[NUM_GPIO-1:0] = filt;
            ADDR_RISE_EN:   rdata_d[NUM_GPIO-1:0] = rise_en_q;
            ADDR_FALL_EN:   rdata_d[NUM_GPIO-1:0] = fall_en_q;
            ADDR_STATUS:    rdata_d[NUM_GPIO-1:0] = status_q;
            ADDR_IRQ_EN:    rdata_d[NUM_GPIO-1:0] = irq_en_q;
            ADDR_DB_CYCLES: rdata_d[DB_WIDTH-1:0] = db_cycles_q;
            default: ;
        endcase
    end

    // Read data is captured on a read strobe and held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (cfg_rd) begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata   = rdata_q;
    assign o_gpio_filt = filt;
    assign o_irq       = |(status_q & irq_en_q);

endmodule

// File: tb/tb_altusoc_gpio_in.sv
// Self-checking bench for altusoc_gpio_in: register vector table plus edge sequences.
module tb_altusoc_gpio_in;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_gpio;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [3:0]  o_gpio_filt;
    logic        o_irq;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    altusoc_gpio_in u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_gpio      (i_gpio),
        .cfg_wr      (cfg_wr),
        .cfg_rd      (cfg_rd),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .o_gpio_filt (o_gpio_filt),
        .o_irq       (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One register-port cycle; a read pushes its expectation onto the scoreboard.
    task automatic access(input logic wr, input logic rd, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input string name);
        cfg_wr    = wr;
        cfg_rd    = rd;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        if (rd) exp_q.push_back('{name, exp});
        step();
        cfg_wr = 1'b0;
        cfg_rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] wdata);
        access(1'b1, 1'b0, addr, wdata, 32'h0, "");
    endtask

    task automatic rd_reg(input logic [4:0] addr, input logic [31:0] exp, input string name);
        access(1'b0, 1'b1, addr, 32'h0, exp, name);
    endtask

    // Scoreboard: pop and compare once the DUT has registered the read.
    always @(posedge clk) begin
        if (rst_n && cfg_rd) begin
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got read data 0x%0h, expected no pending read",
                         cfg_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, cfg_rdata, e.val);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        i_gpio    = 4'b1010;
        cfg_wr    = 1'b0;
        cfg_rd    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;

        // Reset state with pins held at 1010.
        step(3);
        check("rst_filt", 32'(o_gpio_filt), 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        check("rst_rdata", cfg_rdata, 32'h0);

        // Release; enables set during the priming window must not flag edges.
        rst_n = 1'b1;
        wr_reg(5'h04, 32'hF);
        wr_reg(5'h08, 32'hF);
        check("prime_filt_e2", 32'(o_gpio_filt), 32'h0);
        step();
        check("prime_filt_e3", 32'(o_gpio_filt), 32'hA);
        check("prime_irq", 32'(o_irq), 32'h0);
        rd_reg(5'h0C, 32'h0, "prime_status");

        // Register vector table: {wr, rd, addr, wdata, expected read}.
        vecs.push_back('{1'b1, 1'b1, 5'h04, 32'hFFFF_FFFA, 32'hF});
        vecs.push_back('{1'b0, 1'b1, 5'h04, 32'h0,         32'hA});
        vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0000_0135, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 5'h08, 32'h0,         32'h5});
        vecs.push_back('{1'b1, 1'b0, 5'h10, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 5'h11, 32'h0,         32'hF});
        vecs.push_back('{1'b1, 1'b0, 5'h14, 32'h0000_1234, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 5'h14, 32'h0,         32'h34});
        vecs.push_back('{1'b1, 1'b1, 5'h00, 32'hFFFF_FFFF, 32'hA});
        vecs.push_back('{1'b0, 1'b1, 5'h00, 32'h0,         32'hA});
        vecs.push_back('{1'b1, 1'b1, 5'h18, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 5'h1C, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'h0C, 32'hF,         32'h0});
        vecs.push_back('{1'b0, 1'b1, 5'h0C, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 5'h10, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b1, 5'h14, 32'h0,         32'h34});
        vecs.push_back('{1'b0, 1'b1, 5'h14, 32'h0,         32'h0});
        for (int v = 0; v < vecs.size(); v++) begin
            access(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].exp,
                   $sformatf("vec%0d", v));
        end
        check("vec_irq", 32'(o_irq), 32'h0);

        // Rise on pin 0 with no debounce: filt, status and irq on edge 3.
        wr_reg(5'h04, 32'h1);
        wr_reg(5'h10, 32'h1);
        i_gpio = 4'b1011;
        step(2);
        check("rise0_filt_e2", 32'(o_gpio_filt), 32'hA);
        check("rise0_irq_e2", 32'(o_irq), 32'h0);
        step();
        check("rise0_filt_e3", 32'(o_gpio_filt), 32'hB);
        check("rise0_irq_e3", 32'(o_irq), 32'h1);
        rd_reg(5'h0C, 32'h1, "rise0_status");
        wr_reg(5'h0C, 32'h1);
        check("rise0_irq_clr", 32'(o_irq), 32'h0);
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h10, 32'h0);

        // Debounce of 5: a 4-cycle pulse is rejected, a long one lands on edge 8.
        i_gpio = 4'b1001;
        step(4);
        check("db_pre_filt", 32'(o_gpio_filt), 32'h9);
        wr_reg(5'h14, 32'h5);
        wr_reg(5'h04, 32'h2);
        i_gpio = 4'b1011;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("glitch_filt_e%0d", c + 1), 32'(o_gpio_filt), 32'h9);
        end
        i_gpio = 4'b1001;
        step(6);
        check("glitch_filt_after", 32'(o_gpio_filt), 32'h9);
        rd_reg(5'h0C, 32'h0, "glitch_status");
        i_gpio = 4'b1011;
        step(7);
        check("db5_filt_e7", 32'(o_gpio_filt), 32'h9);
        step();
        check("db5_filt_e8", 32'(o_gpio_filt), 32'hB);
        rd_reg(5'h0C, 32'h2, "db5_status");

        // Fall on pin 2, then W1C drops irq on the following cycle.
        wr_reg(5'h14, 32'h0);
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h0C, 32'hF);
        i_gpio = 4'b1111;
        step(4);
        check("fall2_pre_filt", 32'(o_gpio_filt), 32'hF);
        wr_reg(5'h08, 32'h4);
        wr_reg(5'h10, 32'h4);
        check("fall2_pre_irq", 32'(o_irq), 32'h0);
        i_gpio = 4'b1011;
        step(2);
        check("fall2_irq_e2", 32'(o_irq), 32'h0);
        step();
        check("fall2_filt_e3", 32'(o_gpio_filt), 32'hB);
        check("fall2_irq_e3", 32'(o_irq), 32'h1);
        rd_reg(5'h0C, 32'h4, "fall2_status");
        wr_reg(5'h0C, 32'h4);
        check("fall2_irq_clr", 32'(o_irq), 32'h0);
        rd_reg(5'h0C, 32'h0, "fall2_status_clr");

        // Pin 3: set by a fall, then W1C coincides with a new rise -> set wins.
        wr_reg(5'h08, 32'h8);
        wr_reg(5'h04, 32'h8);
        wr_reg(5'h10, 32'h8);
        i_gpio = 4'b0011;
        step(3);
        check("p3_fall_filt", 32'(o_gpio_filt), 32'h3);
        check("p3_fall_irq", 32'(o_irq), 32'h1);
        rd_reg(5'h0C, 32'h8, "p3_fall_status");
        i_gpio = 4'b1011;
        step(2);
        wr_reg(5'h0C, 32'h8);
        check("p3_rise_filt", 32'(o_gpio_filt), 32'hB);
        check("p3_collide_irq", 32'(o_irq), 32'h1);
        rd_reg(5'h0C, 32'h8, "p3_collide_status");
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h08, 32'h0);
        rd_reg(5'h0C, 32'h8, "p3_en_change_status");
        wr_reg(5'h0C, 32'h8);
        rd_reg(5'h0C, 32'h0, "p3_cleared_status");
        check("p3_cleared_irq", 32'(o_irq), 32'h0);

        // Reset asserted while pin 0 is 3 counts into a debounce of 5.
        wr_reg(5'h08, 32'hF);
        wr_reg(5'h10, 32'hF);
        i_gpio = 4'b1010;
        step(3);
        check("mid_pre_irq", 32'(o_irq), 32'h1);
        wr_reg(5'h14, 32'h5);
        rd_reg(5'h14, 32'h5, "mid_db_read");
        i_gpio = 4'b1011;
        step(5);
        check("mid_pre_filt", 32'(o_gpio_filt), 32'hA);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_filt", 32'(o_gpio_filt), 32'h0);
        check("mid_rst_irq", 32'(o_irq), 32'h0);
        check("mid_rst_rdata", cfg_rdata, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("mid_rel_filt_e2", 32'(o_gpio_filt), 32'h0);
        step();
        check("mid_rel_filt_e3", 32'(o_gpio_filt), 32'hB);
        rd_reg(5'h14, 32'h0, "mid_rel_db");
        rd_reg(5'h0C, 32'h0, "mid_rel_status");
        rd_reg(5'h08, 32'h0, "mid_rel_fall_en");
        rd_reg(5'h10, 32'h0, "mid_rel_irq_en");
        check("mid_rel_irq", 32'(o_irq), 32'h0);

        step(2);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
